// File: rtl/cdf_pkg.sv
// Shared constants and FSM state type for the CDF stream reader.
package cdf_pkg;

    localparam int NUM_BINS = 256;
    localparam int LANES    = 4;
    localparam int WORDS    = NUM_BINS / LANES;
    localparam int LANE_W   = 32;
    localparam int CDF_W    = 20;
    localparam int WORD_W   = LANES * LANE_W;

    // Index of the final memory word of a pass.
    localparam logic [5:0] LAST_WORD = 6'(WORDS - 1);
    // Index of the final lane within a word.
    localparam logic [1:0] LAST_LANE = 2'(LANES - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        EMIT = 3'd3,
        DONE = 3'd4
    } cdf_rd_state_t;

endpackage

// File: rtl/cdf_stream_reader.sv
// Reads a 256-bin CDF table (64 words x 4 lanes) from a synchronous memory
// and streams (bin, cdf - cdf_min) pairs out over a valid/ready handshake.
// All outputs come straight from flops; next-state and next-output values
// are computed together so the registered outputs line up with the state.
module cdf_stream_reader
    import cdf_pkg::*;
#(
    parameter logic [15:0] BASE0 = 16'h0000,
    parameter logic [15:0] BASE1 = 16'h0040
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 input_base_offset,
    input  logic [19:0]          Cdf_Min,
    output logic [15:0]          CDF_ReadAddress,
    input  logic [127:0]         CDF_ReadBus,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_bin,
    output logic [19:0]          out_value,
    output logic                 busy,
    output logic                 done
);

    // State and datapath flops.
    cdf_rd_state_t       state_q,     state_d;
    logic [5:0]          word_cnt_q,  word_cnt_d;
    logic [1:0]          lane_q,      lane_d;
    logic [15:0]         base_q,      base_d;
    logic [CDF_W-1:0]    cdf_min_q,   cdf_min_d;
    logic [WORD_W-1:0]   word_q,      word_d;
    logic [15:0]         addr_q,      addr_d;

    // Registered output flops.
    logic                out_valid_q, out_valid_d;
    logic [7:0]          out_bin_q,   out_bin_d;
    logic [CDF_W-1:0]    out_value_q, out_value_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;

    // Lane mux / subtract working signals.
    logic                load_out_s;
    logic [WORD_W-1:0]   lane_src_s;
    logic [1:0]          lane_sel_s;
    logic [CDF_W-1:0]    lane_val_s;

    // Next-state, counters, address and registered-output computation.
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        lane_d      = lane_q;
        base_d      = base_q;
        cdf_min_d   = cdf_min_q;
        word_d      = word_q;
        addr_d      = addr_q;
        out_bin_d   = out_bin_q;
        out_value_d = out_value_q;
        load_out_s  = 1'b0;
        lane_src_s  = word_q;
        lane_sel_s  = lane_q;
        lane_val_s  = {CDF_W{1'b0}};

        case (state_q)
            IDLE: begin
                addr_d = base_q;
                if (start) begin
                    // Pass parameters are frozen here; later input changes are ignored.
                    base_d     = input_base_offset ? BASE1 : BASE0;
                    cdf_min_d  = Cdf_Min;
                    word_cnt_d = 6'd0;
                    lane_d     = 2'd0;
                    addr_d     = base_d;
                    state_d    = READ;
                end else begin
                    state_d    = IDLE;
                end
            end
            READ: begin
                // Address is already presented; memory answers next cycle.
                state_d = WAIT;
            end
            WAIT: begin
                // Capture the word and preload lane 0 onto the output flops.
                word_d     = CDF_ReadBus;
                lane_src_s = CDF_ReadBus;
                lane_sel_s = 2'd0;
                load_out_s = 1'b1;
                state_d    = EMIT;
            end
            EMIT: begin
                if (out_ready) begin
                    if (lane_q == LAST_LANE) begin
                        lane_d = 2'd0;
                        if (word_cnt_q == LAST_WORD) begin
                            state_d = DONE;
                        end else begin
                            word_cnt_d = word_cnt_q + 6'd1;
                            addr_d     = base_q + {10'd0, word_cnt_q + 6'd1};
                            state_d    = READ;
                        end
                    end else begin
                        lane_d     = lane_q + 2'd1;
                        lane_sel_s = lane_q + 2'd1;
                        load_out_s = 1'b1;
                    end
                end else begin
                    // Stalled: every output flop holds.
                    state_d = EMIT;
                end
            end
            DONE: begin
                addr_d  = base_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Lane mux feeding a saturating 20-bit subtract.
        lane_val_s = lane_src_s[{lane_sel_s, 5'd0} +: CDF_W];
        if (load_out_s) begin
            out_bin_d = {word_cnt_q, lane_sel_s};
            if (lane_val_s >= cdf_min_q) begin
                out_value_d = lane_val_s - cdf_min_q;
            end else begin
                out_value_d = {CDF_W{1'b0}};
            end
        end else begin
            out_bin_d   = out_bin_q;
            out_value_d = out_value_q;
        end

        // Status outputs follow the state being entered.
        out_valid_d = (state_d == EMIT);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            word_cnt_q  <= 6'd0;
            lane_q      <= 2'd0;
            base_q      <= 16'd0;
            cdf_min_q   <= {CDF_W{1'b0}};
            word_q      <= {WORD_W{1'b0}};
            addr_q      <= 16'd0;
            out_valid_q <= 1'b0;
            out_bin_q   <= 8'd0;
            out_value_q <= {CDF_W{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            lane_q      <= lane_d;
            base_q      <= base_d;
            cdf_min_q   <= cdf_min_d;
            word_q      <= word_d;
            addr_q      <= addr_d;
            out_valid_q <= out_valid_d;
            out_bin_q   <= out_bin_d;
            out_value_q <= out_value_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign CDF_ReadAddress = addr_q;
    assign out_valid       = out_valid_q;
    assign out_bin         = out_bin_q;
    assign out_value       = out_value_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_cdf_stream_reader.sv
// Self-checking bench for cdf_stream_reader: a synchronous memory model,
// randomized backpressure and a table-lookup reference for expected values.
module tb_cdf_stream_reader;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         input_base_offset;
    logic [19:0]  Cdf_Min;
    logic [15:0]  CDF_ReadAddress;
    logic [127:0] CDF_ReadBus;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_bin;
    logic [19:0]  out_value;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    logic [127:0] mem [0:127];

    // Observations collected by run_pass.
    logic [7:0]  obs_bin  [$];
    logic [19:0] obs_val  [$];
    logic [15:0] obs_addr [$];
    int          done_cnt, done_cyc, unstable, post_done, post_busy;
    bit          timed_out, start_busy, busy_after_done, busy_restart;
    logic [46:0] rst_snap;

    cdf_stream_reader #(.BASE0(16'h0000), .BASE1(16'h0040)) dut (
        .clock(clock), .reset(reset), .start(start),
        .input_base_offset(input_base_offset), .Cdf_Min(Cdf_Min),
        .CDF_ReadAddress(CDF_ReadAddress), .CDF_ReadBus(CDF_ReadBus),
        .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
        .out_value(out_value), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // Synchronous memory: data appears the cycle after its address.
    always @(posedge clock) CDF_ReadBus <= mem[CDF_ReadAddress[6:0]];

    // Reference: bin b lives in word base+b/4, lane b%4; subtract saturates at 0.
    function automatic logic [19:0] exp_val(input int base_w, input int bin, input logic [19:0] cmin);
        logic [127:0] wd;
        logic [19:0]  v;
        wd = mem[base_w + bin / 4];
        v  = wd[(bin % 4) * 32 +: 20];
        return (v >= cmin) ? (v - cmin) : 20'd0;
    endfunction

    task automatic fill_counting();
        for (int w = 0; w < 128; w++)
            for (int k = 0; k < 4; k++)
                mem[w][k*32 +: 32] = 32'(4 * (w % 64) + k + 100);
    endtask

    task automatic fill_random();
        for (int w = 0; w < 128; w++)
            for (int k = 0; k < 4; k++)
                mem[w][k*32 +: 32] = $urandom;
    endtask

    // Runs one pass, recording accepted transfers and timing; optionally resets at abort_bin.
    task automatic run_pass(input bit off, input logic [19:0] cmin, input int ready_pct,
                            input bit hold_start, input int abort_bin, input bit scramble);
        int cyc;
        bit fin, prev_stall;
        logic [7:0]  pb;
        logic [19:0] pv;
        obs_bin.delete(); obs_val.delete(); obs_addr.delete();
        done_cnt = 0; done_cyc = -1; unstable = 0; post_done = 0; post_busy = 0;
        timed_out = 0; busy_after_done = 1'b1; busy_restart = 1'b0; rst_snap = '1;
        input_base_offset = off; Cdf_Min = cmin; start = 1'b1; out_ready = 1'b0;
        @(posedge clock); #1;
        if (!hold_start) start = 1'b0;
        start_busy = busy;
        cyc = 0; fin = 0; prev_stall = 0; pb = 8'd0; pv = 20'd0;
        while (!fin) begin
            if (prev_stall && (out_valid !== 1'b1 || out_bin !== pb || out_value !== pv)) unstable++;
            if (abort_bin >= 0 && out_valid === 1'b1 && int'(out_bin) == abort_bin) begin
                reset = 1'b1;
                #1;
                rst_snap = {out_valid, busy, done, out_bin, out_value, CDF_ReadAddress};
                @(posedge clock); #1;
                reset = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    @(posedge clock); #1;
                    if (done !== 1'b0) post_done++;
                    if (busy !== 1'b0) post_busy++;
                end
                fin = 1;
            end else begin
                if (scramble) begin
                    input_base_offset = 1'($urandom);
                    Cdf_Min = 20'($urandom);
                end
                out_ready = (int'($urandom_range(0, 99)) < ready_pct);
                if (out_valid === 1'b1 && out_ready) begin
                    obs_bin.push_back(out_bin);
                    obs_val.push_back(out_value);
                    obs_addr.push_back(CDF_ReadAddress);
                end
                prev_stall = (out_valid === 1'b1) && !out_ready;
                pb = out_bin; pv = out_value;
                @(posedge clock); #1;
                cyc++;
                if (done === 1'b1) begin
                    done_cnt++;
                    if (done_cyc < 0) done_cyc = cyc;
                end
                if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after_done = busy;
                if (done_cyc >= 0 && cyc == done_cyc + 2) begin
                    busy_restart = busy;
                    fin = 1;
                end
                if (cyc > 6000) begin
                    timed_out = 1;
                    fin = 1;
                end
            end
        end
        start = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; input_base_offset = 1'b0; Cdf_Min = 20'd0; out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        total++;
        if ({out_valid, busy, done, out_bin, out_value, CDF_ReadAddress} !== 47'd0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b b=%b d=%b bin=%0d val=%0d addr=%0d, want all 0",
                     out_valid, busy, done, out_bin, out_value, CDF_ReadAddress);
        end
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        total++;
        if (busy !== 1'b0 || CDF_ReadAddress !== 16'd0) begin
            bad++;
            $display("FAIL idle_after_reset: got busy=%b addr=%0d, want busy=0 addr=0", busy, CDF_ReadAddress);
        end
    endtask

    task automatic test_counting();
        int errs = 0;
        fill_counting();
        run_pass(1'b0, 20'd100, 100, 1'b0, -1, 1'b0);
        for (int i = 0; i < obs_bin.size(); i++)
            if (obs_bin[i] !== 8'(i) || obs_val[i] !== exp_val(0, i, 20'd100) || obs_addr[i] !== 16'(i / 4)) errs++;
        total++;
        if (obs_bin.size() != 256 || errs != 0) begin
            bad++;
            $display("FAIL count_stream: got %0d transfers %0d wrong, want 256 with 0 wrong", obs_bin.size(), errs);
        end
        total++;
        if (obs_val.size() != 256 || obs_val[255] !== 20'd255) begin
            bad++;
            $display("FAIL count_last_value: got %0d transfers, want last value 255", obs_val.size());
        end
        total++;
        if (done_cyc != 384 || done_cnt != 1 || timed_out) begin
            bad++;
            $display("FAIL count_done_timing: got cycle=%0d count=%0d timeout=%b, want 384 and 1", done_cyc, done_cnt, timed_out);
        end
        total++;
        if (start_busy !== 1'b1 || busy_after_done !== 1'b0 || busy_restart !== 1'b0) begin
            bad++;
            $display("FAIL count_busy: got start=%b after_done=%b later=%b, want 1 0 0", start_busy, busy_after_done, busy_restart);
        end
        total++;
        if (CDF_ReadAddress !== 16'h0000) begin
            bad++;
            $display("FAIL count_idle_addr: got %h, want 0000", CDF_ReadAddress);
        end
    endtask

    task automatic test_offset();
        int errs = 0;
        logic [19:0] cm;
        fill_random();
        cm = 20'($urandom_range(0, 20'h80000));
        run_pass(1'b1, cm, 100, 1'b0, -1, 1'b0);
        for (int i = 0; i < obs_bin.size(); i++)
            if (obs_bin[i] !== 8'(i) || obs_val[i] !== exp_val(64, i, cm) || obs_addr[i] !== 16'(64 + i / 4)) errs++;
        total++;
        if (obs_bin.size() != 256 || errs != 0) begin
            bad++;
            $display("FAIL offset_stream: got %0d transfers %0d wrong, want 256 with 0 wrong", obs_bin.size(), errs);
        end
        total++;
        if (done_cyc != 384 || done_cnt != 1) begin
            bad++;
            $display("FAIL offset_done: got cycle=%0d count=%0d, want 384 and 1", done_cyc, done_cnt);
        end
        total++;
        if (CDF_ReadAddress !== 16'h0040) begin
            bad++;
            $display("FAIL offset_idle_addr: got %h, want 0040", CDF_ReadAddress);
        end
    endtask

    task automatic test_saturation();
        fill_random();
        mem[0][31:0]   = {12'hABC, 20'd50};
        mem[0][63:32]  = {12'h000, 20'hFFFFF};
        mem[0][95:64]  = {12'hFFF, 20'd100};
        mem[0][127:96] = {12'h123, 20'd101};
        run_pass(1'b0, 20'd100, 100, 1'b0, -1, 1'b0);
        total++;
        if (obs_val.size() < 4 || obs_val[0] !== 20'd0 || obs_val[1] !== 20'hFFF9B ||
            obs_val[2] !== 20'd0 || obs_val[3] !== 20'd1) begin
            bad++;
            $display("FAIL sat_min100: got %0d transfers first=%h,%h,%h,%h, want 00000,fff9b,00000,00001",
                     obs_val.size(), obs_val.size() > 0 ? obs_val[0] : 20'd0, obs_val.size() > 1 ? obs_val[1] : 20'd0,
                     obs_val.size() > 2 ? obs_val[2] : 20'd0, obs_val.size() > 3 ? obs_val[3] : 20'd0);
        end
        run_pass(1'b0, 20'd0, 100, 1'b0, -1, 1'b0);
        total++;
        if (obs_val.size() < 2 || obs_val[0] !== 20'd50 || obs_val[1] !== 20'hFFFFF) begin
            bad++;
            $display("FAIL sat_min0: got %0d transfers, want bin0=50 bin1=fffff", obs_val.size());
        end
    endtask

    task automatic test_backpressure();
        int errs = 0;
        logic [19:0] cm;
        fill_random();
        cm = 20'($urandom);
        run_pass(1'b0, cm, 30, 1'b0, -1, 1'b0);
        for (int i = 0; i < obs_bin.size(); i++)
            if (obs_bin[i] !== 8'(i) || obs_val[i] !== exp_val(0, i, cm) || obs_addr[i] !== 16'(i / 4)) errs++;
        total++;
        if (obs_bin.size() != 256 || errs != 0) begin
            bad++;
            $display("FAIL bp_stream: got %0d transfers %0d wrong, want 256 with 0 wrong", obs_bin.size(), errs);
        end
        total++;
        if (unstable != 0) begin
            bad++;
            $display("FAIL bp_stable: got %0d unstable stalled cycles, want 0", unstable);
        end
        total++;
        if (done_cnt != 1 || timed_out) begin
            bad++;
            $display("FAIL bp_done: got %0d done pulses timeout=%b, want 1", done_cnt, timed_out);
        end
    endtask

    task automatic test_reset_mid_pass();
        int errs = 0;
        fill_random();
        run_pass(1'b0, 20'd1000, 70, 1'b0, 130, 1'b0);
        total++;
        if (rst_snap !== 47'd0) begin
            bad++;
            $display("FAIL abort_reset_values: got %h, want 0", rst_snap);
        end
        total++;
        if (done_cnt != 0 || post_done != 0 || post_busy != 0) begin
            bad++;
            $display("FAIL abort_no_done: got done=%0d post_done=%0d post_busy=%0d, want 0 0 0", done_cnt, post_done, post_busy);
        end
        run_pass(1'b0, 20'd1000, 70, 1'b0, -1, 1'b0);
        for (int i = 0; i < obs_bin.size(); i++)
            if (obs_bin[i] !== 8'(i) || obs_val[i] !== exp_val(0, i, 20'd1000)) errs++;
        total++;
        if (obs_bin.size() != 256 || errs != 0 || done_cnt != 1) begin
            bad++;
            $display("FAIL abort_restart: got %0d transfers %0d wrong done=%0d, want 256 0 1", obs_bin.size(), errs, done_cnt);
        end
    endtask

    task automatic test_hold_start();
        int errs = 0;
        logic [19:0] cm;
        fill_random();
        cm = 20'($urandom_range(0, 20'h40000));
        run_pass(1'b1, cm, 80, 1'b1, -1, 1'b1);
        for (int i = 0; i < obs_bin.size(); i++)
            if (obs_bin[i] !== 8'(i) || obs_val[i] !== exp_val(64, i, cm) || obs_addr[i] !== 16'(64 + i / 4)) errs++;
        total++;
        if (obs_bin.size() != 256 || errs != 0) begin
            bad++;
            $display("FAIL hold_stream: got %0d transfers %0d wrong, want 256 with 0 wrong", obs_bin.size(), errs);
        end
        total++;
        if (done_cnt != 1 || busy_after_done !== 1'b0 || busy_restart !== 1'b1) begin
            bad++;
            $display("FAIL hold_restart: got done=%0d idle_busy=%b next_busy=%b, want 1 0 1", done_cnt, busy_after_done, busy_restart);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    initial begin
        test_reset();
        test_counting();
        test_offset();
        test_saturation();
        test_backpressure();
        test_reset_mid_pass();
        test_hold_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdf_stream_reader.md
CDF_STREAM_READER -- requirements
Module: cdf_stream_reader

Interface
REQ-001 SHALL have parameter BASE0, default 16'h0000, meaning the word base address used when input_base_offset=0.
REQ-002 SHALL have parameter BASE1, default 16'h0040, meaning the word base address used when input_base_offset=1.
REQ-003 SHALL have port clock, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a level or pulse that begins one 256-bin read pass when idle.
REQ-006 SHALL have port input_base_offset, input, 1, which selects BASE0 or BASE1 and is sampled at start.
REQ-007 SHALL have port Cdf_Min, input, 20, the minimum nonzero CDF, sampled at start.
REQ-008 SHALL have port CDF_ReadAddress, output, 16, the CDF memory word address.
REQ-009 SHALL have port CDF_ReadBus, input, 128, the CDF memory read data, valid the cycle after its address.
REQ-010 SHALL have port out_valid, output, 1, which qualifies out_bin and out_value.
REQ-011 SHALL have port out_ready, input, 1, the downstream accept signal.
REQ-012 SHALL have port out_bin, output, 8, the bin index of the current output.
REQ-013 SHALL have port out_value, output, 20, equal to the CDF value minus Cdf_Min, saturated at 0.
REQ-014 SHALL have port busy, output, 1, high from the accepted start until done.
REQ-015 SHALL have port done, output, 1, a one-cycle pulse after the last bin is accepted.

Function
REQ-016 Word packing SHALL be 4 lanes of 32 bits; lane k = bits [32k+31:32k] = bin 4*word+k; bits [19:0] of each lane are the CDF value and bits [31:20] are ignored.
REQ-017 The FSM SHALL have states IDLE, READ, WAIT, EMIT and DONE.
REQ-018 IDLE->READ SHALL occur on start=1; this transition latches the base, Cdf_Min, word counter=0 and lane=0.
REQ-019 In READ, the FSM SHALL drive CDF_ReadAddress = base + word counter and go to WAIT the next cycle.
REQ-020 In WAIT, the FSM SHALL capture CDF_ReadBus into a 128-bit word register and go to EMIT.
REQ-021 In EMIT, out_valid SHALL be 1, and lane advances only when out_valid && out_ready.
REQ-022 After lane 3 is accepted: if word counter=63 -> DONE, else word counter+1 -> READ.
REQ-023 In DONE, done=1 for exactly one cycle, then -> IDLE; busy SHALL be 0 in IDLE only.
REQ-024 out_bin, out_value and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 out_value SHALL be lane[19:0] - Cdf_Min if lane[19:0] >= Cdf_Min, else 0; the arithmetic is 20-bit with no wrap.
REQ-026 start SHALL be ignored outside IDLE, and input_base_offset and Cdf_Min changes mid-pass SHALL have no effect.
REQ-027 The address SHALL be base+counter modulo 2^16, wrapping silently.
REQ-028 CDF_ReadAddress SHALL hold its last value outside READ and SHALL be base in IDLE.
REQ-029 Exactly 256 accepted transfers SHALL occur per pass, in bin order 0..255, with no duplicates or skips.
REQ-030 With out_ready held at 1, a pass SHALL take 64*(1+1+4) = 384 cycles from READ entry to DONE.
REQ-031 When start=1 in the same cycle as DONE, that start SHALL be ignored; a new pass requires start while in IDLE.

Reset
REQ-032 reset=1 SHALL asynchronously force state IDLE, out_valid=0, done=0, busy=0, out_bin=0, out_value=0, CDF_ReadAddress=0, and the counters, word register and latched Cdf_Min to 0.
REQ-033 Reset mid-pass SHALL abandon the pass with no done pulse, and the next start SHALL begin again at bin 0.

Structure
REQ-034 Shared package cdf_pkg SHALL hold NUM_BINS=256, LANES=4, WORDS=64, LANE_W=32, CDF_W=20 and the state enum cdf_rd_state_t.
REQ-035 The block SHALL be a single module with no sub-module; the lane mux and saturating subtract are inline.

Verification
REQ-036 Memory word w lane k = 4w+k+100, Cdf_Min=100, offset=0, out_ready=1 -> bins 0..255 with out_value = bin, done at cycle 384, addresses 0..63.
REQ-037 offset=1 with base data at 16'h0040..16'h007F -> addresses 64..127 are read and values match that region.
REQ-038 Lane value 50 with Cdf_Min=100 -> out_value=0; lane 20'hFFFFF with Cdf_Min=0 -> out_value=20'hFFFFF.
REQ-039 out_ready random at 30% duty -> 256 in-order transfers, outputs stable while stalled, done exactly once.
REQ-040 reset asserted at bin 130, then start -> first output bin 0, and no done pulse from the aborted pass.
REQ-041 start held high through a whole pass -> a second pass begins only after IDLE is re-entered, and Cdf_Min changes mid-pass are ignored.
